operand_fetch_stage: RTL and testbench
======================================

Name: operand_fetch_stage

Overview:
- Decode-side operand fetch plus the ID/EX pipeline register of the RV32 core.
- Drives the register file read addresses and takes its combinational read data.
- Bypasses MEM/WB results, detects load-use hazards and inserts bubbles.
- Presents a registered, valid/ready operand bundle to the execute stage.

Parameters:
XLEN, 32, data width
AWIDTH, 5, register address width

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
in_valid  in  1  decoded instruction available
in_ready  out  1  stage accepts instruction this cycle
in_pc  in  XLEN  instruction PC
in_rs1  in  AWIDTH  source 1 index
in_rs2  in  AWIDTH  source 2 index
in_use_rs1  in  1  instruction reads rs1
in_use_rs2  in  1  instruction reads rs2
in_rd  in  AWIDTH  destination index
in_rd_we  in  1  instruction writes rd
in_is_load  in  1  instruction is a load
ra1  out  AWIDTH  regfile read addr 1 (= in_rs1, combinational)
ra2  out  AWIDTH  regfile read addr 2 (= in_rs2, combinational)
rf_rd1  in  XLEN  regfile read data 1
rf_rd2  in  XLEN  regfile read data 2
mem_rd, mem_we, mem_is_load  in  AWIDTH,1,1  instruction now in MEM
mem_data  in  XLEN  MEM-stage ALU result (invalid for loads)
wb_rd, wb_we  in  AWIDTH,1  instruction now in WB (same as regfile write port)
wb_data  in  XLEN  WB write data
flush  in  1  kill held and incoming instruction (branch redirect)
out_valid  out  1  registered bundle valid
out_ready  in  1  execute accepts bundle
out_pc, out_rs1_val, out_rs2_val  out  XLEN  registered operands
out_rd, out_rd_we, out_is_load  out  AWIDTH,1,1  registered dest info

Behaviour:
- Reset (rst_n=0, async): out_valid=0. All other out_* registers = 0. Counters = 0.
- Operand select, per source s, in priority order:
  - s==0 -> 0.
  - mem_we && mem_rd==s && !mem_is_load -> mem_data.
  - wb_we && wb_rd==s -> wb_data.
  - Otherwise rf_rdN.
- WB bypass is mandatory: the regfile write lands only at the clock edge.
- hazard = (used source s != 0) and either:
  - out_valid && out_is_load && out_rd_we && out_rd==s, or
  - mem_we && mem_is_load && mem_rd==s.
- Consequence: load-use costs exactly 2 bubbles.
- adv = !out_valid || out_ready.
- in_ready = adv && !hazard && !flush. Accept = in_valid && in_ready.
- Register update each posedge:
  - flush=1 -> out_valid<=0. The incoming instruction is dropped; it is refetched upstream.
  - Else if adv: accept -> load all out_* regs, out_valid<=1. No accept -> out_valid<=0 (bubble); other out_* may hold.
  - Else (out_valid && !out_ready): hold everything, including through hazard and in_valid changes.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 per cycle with no hazard and out_ready=1.
- Hazard against a stalled load (out_ready=0) is masked by adv=0.
- Reset mid-stall clears out_valid immediately. No instruction survives.

Optional Feature:
- Macro OPFETCH_STATS_EN.
- Defined:
  - Adds out ports stall_cnt[31:0] and fwd_cnt[31:0], both wrapping, reset 0.
  - stall_cnt increments each cycle with in_valid && adv && hazard && !flush.
  - fwd_cnt increments on each accept where at least one used operand came from mem_data or wb_data.
- Undefined: ports and logic absent, remaining behaviour identical.

Test Plan:
- Back-to-back independent ALU ops with out_ready=1 -> in_ready=1 every cycle; out_valid continuous; operands equal regfile values, 1-cycle latency.
- Source rs1=5, with mem_we=1, mem_rd=5, mem_data=0xAAAA0001 and wb_rd=5, wb_data=0x2 -> out_rs1_val=0xAAAA0001 (MEM beats WB). rs=0 with mem_rd=0, mem_data=0xFFFF -> 0.
- Load x7 accepted, next instr uses rs2=7 -> in_ready=0 for 2 cycles, 2 bubbles (out_valid=0); accepted once load reaches WB with wb_data=0x1234 -> out_rs2_val=0x1234. With OPFETCH_STATS_EN: stall_cnt=2, fwd_cnt=1.
- out_ready=0 for 3 cycles with bundle held -> out_* stable, in_ready=0; release -> next instr accepted the same cycle.
- flush asserted while in_valid=1 and out_valid=1 -> next cycle out_valid=0, instruction not presented.
- rst_n low mid-stall (async, between edges) -> out_valid=0 immediately; counters 0 after release.

Source files
------------

// File: rtl/operand_fetch_stage.sv
// RV32 operand fetch with MEM/WB bypass, load-use bubble insertion and the ID/EX register.
// Optional OPFETCH_STATS_EN adds stall_cnt/fwd_cnt performance counters.
module operand_fetch_stage #(
  parameter int XLEN   = 32,
  parameter int AWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [AWIDTH-1:0] in_rs1,
  input  logic [AWIDTH-1:0] in_rs2,
  input  logic              in_use_rs1,
  input  logic              in_use_rs2,
  input  logic [AWIDTH-1:0] in_rd,
  input  logic              in_rd_we,
  input  logic              in_is_load,
  output logic [AWIDTH-1:0] ra1,
  output logic [AWIDTH-1:0] ra2,
  input  logic [XLEN-1:0]   rf_rd1,
  input  logic [XLEN-1:0]   rf_rd2,
  input  logic [AWIDTH-1:0] mem_rd,
  input  logic              mem_we,
  input  logic              mem_is_load,
  input  logic [XLEN-1:0]   mem_data,
  input  logic [AWIDTH-1:0] wb_rd,
  input  logic              wb_we,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_rs1_val,
  output logic [XLEN-1:0]   out_rs2_val,
  output logic [AWIDTH-1:0] out_rd,
  output logic              out_rd_we,
  output logic              out_is_load
`ifdef OPFETCH_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       fwd_cnt
`endif
);

  logic              r_valid;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_rs1_val;
  logic [XLEN-1:0]   r_rs2_val;
  logic [AWIDTH-1:0] r_rd;
  logic              r_rd_we;
  logic              r_is_load;

  logic              w_nz1, w_nz2;
  logic              w_mem1, w_mem2, w_wb1, w_wb2;
  logic              w_haz1, w_haz2, w_hazard;
  logic              w_adv, w_accept;
  logic [XLEN-1:0]   w_op1, w_op2;

  assign ra1 = in_rs1;
  assign ra2 = in_rs2;

  assign w_nz1  = |in_rs1;
  assign w_nz2  = |in_rs2;
  assign w_mem1 = mem_we && !mem_is_load && (mem_rd == in_rs1);
  assign w_mem2 = mem_we && !mem_is_load && (mem_rd == in_rs2);
  assign w_wb1  = wb_we && (wb_rd == in_rs1);
  assign w_wb2  = wb_we && (wb_rd == in_rs2);

  // Later assignments win: x0 over MEM over WB over regfile.
  always_comb begin
    w_op1 = rf_rd1;
    if (w_wb1)  w_op1 = wb_data;
    if (w_mem1) w_op1 = mem_data;
    if (!w_nz1) w_op1 = '0;
    w_op2 = rf_rd2;
    if (w_wb2)  w_op2 = wb_data;
    if (w_mem2) w_op2 = mem_data;
    if (!w_nz2) w_op2 = '0;
  end

  // A load is unresolvable while in EX (our register) or in MEM (data not yet returned).
  assign w_haz1 = in_use_rs1 && w_nz1 &&
                  ((r_valid && r_is_load && r_rd_we && (r_rd == in_rs1)) ||
                   (mem_we && mem_is_load && (mem_rd == in_rs1)));
  assign w_haz2 = in_use_rs2 && w_nz2 &&
                  ((r_valid && r_is_load && r_rd_we && (r_rd == in_rs2)) ||
                   (mem_we && mem_is_load && (mem_rd == in_rs2)));
  assign w_hazard = w_haz1 || w_haz2;

  assign w_adv    = !r_valid || out_ready;
  assign in_ready = w_adv && !w_hazard && !flush;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_rs1_val <= '0;
      r_rs2_val <= '0;
      r_rd      <= '0;
      r_rd_we   <= 1'b0;
      r_is_load <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_adv) begin
      if (w_accept) begin
        r_valid   <= 1'b1;
        r_pc      <= in_pc;
        r_rs1_val <= w_op1;
        r_rs2_val <= w_op2;
        r_rd      <= in_rd;
        r_rd_we   <= in_rd_we;
        r_is_load <= in_is_load;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid   = r_valid;
  assign out_pc      = r_pc;
  assign out_rs1_val = r_rs1_val;
  assign out_rs2_val = r_rs2_val;
  assign out_rd      = r_rd;
  assign out_rd_we   = r_rd_we;
  assign out_is_load = r_is_load;

`ifdef OPFETCH_STATS_EN
  logic        w_fwd;
  logic [31:0] r_stall_cnt;
  logic [31:0] r_fwd_cnt;

  assign w_fwd = (in_use_rs1 && w_nz1 && (w_mem1 || w_wb1)) ||
                 (in_use_rs2 && w_nz2 && (w_mem2 || w_wb2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      if (in_valid && w_adv && w_hazard && !flush) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_accept && w_fwd)                       r_fwd_cnt   <= r_fwd_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign fwd_cnt   = r_fwd_cnt;
`endif

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench for operand_fetch_stage: directed scenarios plus a randomized run
// against a cycle-level reference model. Build with +define+OPFETCH_STATS_EN to cover counters.
module tb_operand_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_pc;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_use_rs1, in_use_rs2, in_rd_we, in_is_load;
  logic [4:0]  ra1, ra2;
  logic [31:0] rf_rd1, rf_rd2;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_we, mem_is_load, wb_we;
  logic [31:0] mem_data, wb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_rs1_val, out_rs2_val;
  logic [4:0]  out_rd;
  logic        out_rd_we, out_is_load;
`ifdef OPFETCH_STATS_EN
  logic [31:0] stall_cnt, fwd_cnt;
`endif

  int errs = 0;
  int chks = 0;

  always #5 clk = ~clk;

  operand_fetch_stage #(.XLEN(32), .AWIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
    .in_rd(in_rd), .in_rd_we(in_rd_we), .in_is_load(in_is_load),
    .ra1(ra1), .ra2(ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .mem_rd(mem_rd), .mem_we(mem_we), .mem_is_load(mem_is_load), .mem_data(mem_data),
    .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .out_is_load(out_is_load)
`ifdef OPFETCH_STATS_EN
    , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle;
    in_valid = 0; in_pc = 0; in_rs1 = 0; in_rs2 = 0; in_use_rs1 = 0; in_use_rs2 = 0;
    in_rd = 0; in_rd_we = 0; in_is_load = 0; rf_rd1 = 0; rf_rd2 = 0;
    mem_rd = 0; mem_we = 0; mem_is_load = 0; mem_data = 0;
    wb_rd = 0; wb_we = 0; wb_data = 0; flush = 0; out_ready = 1;
  endtask

  task automatic set_instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic ld);
    in_valid = 1; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_use_rs1 = 1; in_use_rs2 = 1;
    in_rd = rd; in_rd_we = 1; in_is_load = ld;
  endtask

  task automatic test_reset;
    set_idle();
    rst_n = 0;
    #12;
    rst_n = 1;
    tick();
    chks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    chks++; if ({out_pc, out_rs1_val, out_rs2_val, out_rd, out_rd_we, out_is_load} !== '0) begin
      errs++; $display("FAIL reset_regs got pc=%h a=%h b=%h exp all zero", out_pc, out_rs1_val, out_rs2_val); end
    chks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
`ifdef OPFETCH_STATS_EN
    chks++; if (stall_cnt !== 0 || fwd_cnt !== 0) begin
      errs++; $display("FAIL reset_counters got stall=%0d fwd=%0d exp 0 0", stall_cnt, fwd_cnt); end
`endif
  endtask

  task automatic test_load_use;
    set_idle();
    set_instr(32'h200, 5'd1, 5'd2, 5'd7, 1'b1);
    #1;
    chks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL lu_load_ready got=%b exp=1", in_ready); end
    tick();
    chks++; if (out_valid !== 1'b1 || out_is_load !== 1'b1 || out_rd !== 5'd7) begin
      errs++; $display("FAIL lu_load_out got v=%b ld=%b rd=%0d exp 1 1 7", out_valid, out_is_load, out_rd); end
    set_instr(32'h204, 5'd3, 5'd7, 5'd8, 1'b0);
    rf_rd1 = 32'h33; rf_rd2 = 32'h9999;
    #1;
    chks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL lu_stall1_ready got=%b exp=0", in_ready); end
    tick();
    chks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL lu_bubble1 got=%b exp=0", out_valid); end
    mem_we = 1; mem_rd = 7; mem_is_load = 1; mem_data = 32'hBAD0BAD0;
    #1;
    chks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL lu_stall2_ready got=%b exp=0", in_ready); end
    tick();
    chks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL lu_bubble2 got=%b exp=0", out_valid); end
    mem_we = 0; mem_rd = 0; mem_is_load = 0; mem_data = 0;
    wb_we = 1; wb_rd = 7; wb_data = 32'h1234;
    #1;
    chks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL lu_resume_ready got=%b exp=1", in_ready); end
    tick();
    chks++; if (out_valid !== 1'b1 || out_pc !== 32'h204) begin
      errs++; $display("FAIL lu_dep_out got v=%b pc=%h exp 1 204", out_valid, out_pc); end
    chks++; if (out_rs2_val !== 32'h1234 || out_rs1_val !== 32'h33) begin
      errs++; $display("FAIL lu_dep_ops got a=%h b=%h exp 33 1234", out_rs1_val, out_rs2_val); end
`ifdef OPFETCH_STATS_EN
    chks++; if (stall_cnt !== 2 || fwd_cnt !== 1) begin
      errs++; $display("FAIL lu_counters got stall=%0d fwd=%0d exp 2 1", stall_cnt, fwd_cnt); end
`endif
    set_idle();
    tick();
  endtask

  task automatic test_back_to_back;
    logic [31:0] e1, e2;
    set_idle();
    for (int i = 0; i < 8; i++) begin
      set_instr(32'h100 + 32'(4 * i), 5'(1 + i), 5'(10 + i), 5'(20 + i), 1'b0);
      rf_rd1 = $urandom; rf_rd2 = $urandom;
      e1 = rf_rd1; e2 = rf_rd2;
      #1;
      chks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, in_ready); end
      tick();
      chks++; if (out_valid !== 1'b1 || out_pc !== 32'h100 + 32'(4 * i)) begin
        errs++; $display("FAIL b2b_out[%0d] got v=%b pc=%h exp v=1 pc=%h", i, out_valid, out_pc, 32'h100 + 32'(4 * i)); end
      chks++; if (out_rs1_val !== e1 || out_rs2_val !== e2 || out_rd !== 5'(20 + i)) begin
        errs++; $display("FAIL b2b_ops[%0d] got a=%h b=%h rd=%0d exp a=%h b=%h rd=%0d", i, out_rs1_val, out_rs2_val, out_rd, e1, e2, 20 + i); end
    end
    set_idle();
    tick();
    chks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_forward;
    set_idle();
    set_instr(32'h400, 5'd5, 5'd3, 5'd9, 1'b0);
    rf_rd1 = 32'h55; rf_rd2 = 32'h66;
    mem_we = 1; mem_rd = 5; mem_data = 32'hAAAA0001;
    wb_we = 1; wb_rd = 5; wb_data = 32'h2;
    tick();
    chks++; if (out_rs1_val !== 32'hAAAA0001 || out_rs2_val !== 32'h66) begin
      errs++; $display("FAIL fwd_mem_over_wb got a=%h b=%h exp aaaa0001 66", out_rs1_val, out_rs2_val); end
    set_instr(32'h404, 5'd0, 5'd4, 5'd9, 1'b0);
    rf_rd1 = 32'h77; rf_rd2 = 32'h88;
    mem_we = 1; mem_rd = 0; mem_data = 32'hFFFF;
    wb_we = 1; wb_rd = 4; wb_data = 32'hC0DE;
    tick();
    chks++; if (out_rs1_val !== 32'h0 || out_rs2_val !== 32'hC0DE) begin
      errs++; $display("FAIL fwd_x0_and_wb got a=%h b=%h exp 0 c0de", out_rs1_val, out_rs2_val); end
`ifdef OPFETCH_STATS_EN
    chks++; if (fwd_cnt !== 3 || stall_cnt !== 2) begin
      errs++; $display("FAIL fwd_counters got stall=%0d fwd=%0d exp 2 3", stall_cnt, fwd_cnt); end
`endif
    set_idle();
    tick();
  endtask

  task automatic test_backpressure;
    set_idle();
    set_instr(32'h300, 5'd1, 5'd2, 5'd3, 1'b0);
    rf_rd1 = 32'h1111; rf_rd2 = 32'h2222;
    tick();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      set_instr(32'h304, 5'd4, 5'd5, 5'd6, 1'b0);
      in_valid = (i != 1);
      rf_rd1 = $urandom; rf_rd2 = $urandom;
      #1;
      chks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_ready[%0d] got=%b exp=0", i, in_ready); end
      tick();
      chks++; if (out_valid !== 1'b1 || out_pc !== 32'h300 || out_rs1_val !== 32'h1111 || out_rs2_val !== 32'h2222) begin
        errs++; $display("FAIL bp_hold[%0d] got v=%b pc=%h a=%h b=%h exp 1 300 1111 2222", i, out_valid, out_pc, out_rs1_val, out_rs2_val); end
    end
    out_ready = 1; rf_rd1 = 32'hABCD; rf_rd2 = 32'hDCBA;
    #1;
    chks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    tick();
    chks++; if (out_valid !== 1'b1 || out_pc !== 32'h304 || out_rs1_val !== 32'hABCD) begin
      errs++; $display("FAIL bp_release_out got v=%b pc=%h a=%h exp 1 304 abcd", out_valid, out_pc, out_rs1_val); end
    set_idle();
    tick();
  endtask

  task automatic test_flush;
    set_idle();
    set_instr(32'h500, 5'd1, 5'd2, 5'd3, 1'b0);
    tick();
    set_instr(32'h504, 5'd1, 5'd2, 5'd3, 1'b0);
    flush = 1;
    #1;
    chks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL flush_ready got=%b exp=0", in_ready); end
    tick();
    chks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL flush_kill got=%b exp=0", out_valid); end
    set_idle();
    tick();
    chks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL flush_no_present got=%b exp=0", out_valid); end
  endtask

  task automatic test_async_reset;
    set_idle();
    set_instr(32'h600, 5'd1, 5'd2, 5'd3, 1'b1);
    tick();
    out_ready = 0;
    set_instr(32'h604, 5'd3, 5'd1, 5'd4, 1'b0);
    tick();
    #2;
    rst_n = 0;
    #1;
    chks++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_is_load !== 1'b0) begin
      errs++; $display("FAIL areset_immediate got v=%b pc=%h ld=%b exp 0 0 0", out_valid, out_pc, out_is_load); end
    set_idle();
    @(negedge clk);
    rst_n = 1;
    tick();
    chks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL areset_after got=%b exp=0", out_valid); end
`ifdef OPFETCH_STATS_EN
    chks++; if (stall_cnt !== 0 || fwd_cnt !== 0) begin
      errs++; $display("FAIL areset_counters got stall=%0d fwd=%0d exp 0 0", stall_cnt, fwd_cnt); end
`endif
  endtask

  // Reference model: expected EX bundle plus expected counters.
  typedef struct {
    logic v; logic [31:0] pc, a, b; logic [4:0] rd; logic we, ld;
  } bund_t;

  function automatic logic [31:0] ref_op(input logic [4:0] s, input logic [31:0] rf);
    if (s == 0) return 0;
    if (mem_we && mem_rd == s && !mem_is_load) return mem_data;
    if (wb_we && wb_rd == s) return wb_data;
    return rf;
  endfunction

  function automatic logic ref_fwd(input logic [4:0] s, input logic use_s);
    return use_s && s != 0 && ((mem_we && mem_rd == s && !mem_is_load) || (wb_we && wb_rd == s));
  endfunction

  function automatic logic ref_haz(input bund_t m, input logic [4:0] s, input logic use_s);
    return use_s && s != 0 &&
           ((m.v && m.ld && m.we && m.rd == s) || (mem_we && mem_is_load && mem_rd == s));
  endfunction

  task automatic test_random;
    bund_t m;
    logic adv, hz, rdy, acc;
    int unsigned e_stall, e_fwd;
    m = '{v: 0, pc: 0, a: 0, b: 0, rd: 0, we: 0, ld: 0};
    e_stall = 0; e_fwd = 0;
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 9) < 7); in_pc = $urandom;
      in_rs1 = 5'($urandom_range(0, 3)); in_rs2 = 5'($urandom_range(0, 3));
      in_use_rs1 = 1'($urandom); in_use_rs2 = 1'($urandom);
      in_rd = 5'($urandom_range(0, 3)); in_rd_we = 1'($urandom);
      in_is_load = ($urandom_range(0, 9) < 3);
      rf_rd1 = $urandom; rf_rd2 = $urandom;
      mem_rd = 5'($urandom_range(0, 3)); mem_we = 1'($urandom); mem_is_load = 1'($urandom);
      mem_data = $urandom;
      wb_rd = 5'($urandom_range(0, 3)); wb_we = 1'($urandom); wb_data = $urandom;
      flush = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      adv = !m.v || out_ready;
      hz  = ref_haz(m, in_rs1, in_use_rs1) || ref_haz(m, in_rs2, in_use_rs2);
      rdy = adv && !hz && !flush;
      acc = in_valid && rdy;
      chks++; if (in_ready !== rdy || ra1 !== in_rs1 || ra2 !== in_rs2) begin
        errs++; $display("FAIL rnd_comb[%0d] got rdy=%b ra1=%0d ra2=%0d exp rdy=%b ra1=%0d ra2=%0d", c, in_ready, ra1, ra2, rdy, in_rs1, in_rs2); end
      if (in_valid && adv && hz && !flush) e_stall++;
      if (acc && (ref_fwd(in_rs1, in_use_rs1) || ref_fwd(in_rs2, in_use_rs2))) e_fwd++;
      if (flush) m.v = 0;
      else if (adv) begin
        if (acc) m = '{v: 1, pc: in_pc, a: ref_op(in_rs1, rf_rd1), b: ref_op(in_rs2, rf_rd2),
                       rd: in_rd, we: in_rd_we, ld: in_is_load};
        else m.v = 0;
      end
      tick();
      chks++; if (out_valid !== m.v) begin errs++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", c, out_valid, m.v); end
      if (m.v) begin
        chks++; if (out_pc !== m.pc || out_rs1_val !== m.a || out_rs2_val !== m.b ||
                    out_rd !== m.rd || out_rd_we !== m.we || out_is_load !== m.ld) begin
          errs++; $display("FAIL rnd_bundle[%0d] got pc=%h a=%h b=%h rd=%0d we=%b ld=%b exp pc=%h a=%h b=%h rd=%0d we=%b ld=%b",
                           c, out_pc, out_rs1_val, out_rs2_val, out_rd, out_rd_we, out_is_load, m.pc, m.a, m.b, m.rd, m.we, m.ld); end
      end
`ifdef OPFETCH_STATS_EN
      chks++; if (stall_cnt !== e_stall || fwd_cnt !== e_fwd) begin
        errs++; $display("FAIL rnd_counters[%0d] got stall=%0d fwd=%0d exp %0d %0d", c, stall_cnt, fwd_cnt, e_stall, e_fwd); end
`endif
    end
    set_idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_back_to_back();
    test_forward();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
